// File: rtl/spm_seq_mult.sv
// spm_seq_mult -- parametrised carry-save serial-parallel multiplier.
//
// The operands x and y are latched on an accepted start. The product
// P = x*y (mod 2^(2*WIDTH)) is then streamed LSB-first on p_bit/p_vld,
// one bit per clock. The FSM runs IDLE -> RUN -> DONE -> IDLE, and every
// output is registered.
//
// Build option: define SPM_PAR_OUT_EN to add the parallel product port p_par.
//
// Handshake:
//   A start is accepted only on a 0->1 transition of start seen while IDLE,
//   and only when abort is low at the same time.
//   busy is high from the edge after acceptance through the done cycle.
//   p_vld qualifies p_bit for exactly 2*WIDTH cycles.
//   done pulses for one cycle, immediately after the last valid bit.
//   abort in RUN or DONE returns the block to IDLE at the next edge
//   without producing a done pulse.

module spm_seq_mult #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(2*WIDTH+1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               abort,
    output logic               busy,
    output logic               p_bit,
    output logic               p_vld,
    output logic               done,
`ifdef SPM_PAR_OUT_EN
    output logic [2*WIDTH-1:0] p_par,
`endif
    output logic [1:0]         o_dbg_state
);

    // Product width: the chain has one carry-save cell per product bit.
    // Each cell's partial-product input is the sign- or zero-extended
    // multiplicand, so the top cell never needs a special correction term:
    // bits above 2*WIDTH never reach the output.
    localparam int PW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_start_q;     // previous start level, for edge detection
    logic             w_start_rise;
    logic             w_accept;      // operands latched at this edge
    logic             w_emit;        // one product bit produced at this edge
    logic             w_finish;      // RUN -> DONE at this edge

    logic [CNT_W-1:0] r_cnt;         // product bits emitted so far
    logic [PW-1:0]    r_x;           // extended multiplicand
    logic [WIDTH-1:0] r_y;           // multiplier, consumed from bit 0
    logic             r_sgn;

    // Carry-save state.
    //   r_s holds the sum bits of cells 1..PW-1 from the previous cycle.
    //   Cell 0's sum is the emitted bit, so it is not stored.
    //   r_c holds each cell's own carry, which feeds back into that cell:
    //   the frame shifts right by one bit each cycle, so a carry that stays
    //   in place gains exactly the weight it should.
    logic [PW-2:0]    r_s;
    logic [PW-1:0]    r_c;

    logic [PW-1:0]    w_pp;          // partial product x_ext & y_bit
    logic [PW-1:0]    w_sin;         // sum bit arriving from the cell above
    logic [PW-1:0]    w_sum;
    logic [PW-1:0]    w_cry;
    logic             w_y_fill;      // bit shifted into the multiplier MSB

    logic             r_busy;
    logic             r_p_bit;
    logic             r_p_vld;
    logic             r_done;

`ifdef SPM_PAR_OUT_EN
    logic [PW-1:0]    r_par_sh;      // product assembled as bits are emitted
    logic [PW-1:0]    r_p_par;       // last completed product
`endif

    assign w_start_rise = start & ~r_start_q;

    // Carry-save cell array: one full adder per product bit position.
    assign w_pp  = r_x & {PW{r_y[0]}};
    assign w_sin = {1'b0, r_s};
    assign w_sum = w_pp ^ w_sin ^ r_c;
    assign w_cry = (w_pp & w_sin) | (w_pp & r_c) | (w_sin & r_c);

    // Signed operands keep replicating the multiplier sign bit;
    // unsigned operands shift in zeros.
    assign w_y_fill = r_sgn & r_y[WIDTH-1];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic, plus the per-edge actions that the datapath consumes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_emit      = 1'b0;
        w_finish    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // abort takes priority over a simultaneous start.
                if (w_start_rise && !abort) begin
                    w_state_nxt = S_RUN;
                    w_accept    = 1'b1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_DONE;
                    w_finish    = 1'b1;
                end else begin
                    w_emit = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Start edge detector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_start_q <= 1'b0;
        end else begin
            r_start_q <= start;
        end
    end

    // Bit counter.
    // Cleared on accept and advanced once per emitted bit.
    // It holds at 2*WIDTH through DONE and never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (w_emit) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Operand registers.
    // Loaded only on accept; y is then shifted down one bit per emitted bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x   <= '0;
            r_y   <= '0;
            r_sgn <= 1'b0;
        end else if (w_accept) begin
            r_x   <= {{WIDTH{sgn & x[WIDTH-1]}}, x};
            r_y   <= y;
            r_sgn <= sgn;
        end else if (w_emit) begin
            r_y   <= {w_y_fill, r_y[WIDTH-1:1]};
        end
    end

    // Carry-save accumulator.
    // Cleared on accept; advanced by one cell step per emitted bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s <= '0;
            r_c <= '0;
        end else if (w_accept) begin
            r_s <= '0;
            r_c <= '0;
        end else if (w_emit) begin
            r_s <= w_sum[PW-1:1];
            r_c <= w_cry;
        end
    end

    // Registered handshake and serial outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy  <= 1'b0;
            r_p_bit <= 1'b0;
            r_p_vld <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_busy  <= (w_state_nxt != S_IDLE);
            r_p_vld <= w_emit;
            r_p_bit <= w_emit & w_sum[0];
            r_done  <= w_finish;
        end
    end

`ifdef SPM_PAR_OUT_EN
    // Parallel product.
    // Bits are shifted in from the top as they are emitted, so after 2*WIDTH
    // bits the register holds P. The result is published only on a completed
    // operation; an aborted one leaves the previous value in place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_sh <= '0;
            r_p_par  <= '0;
        end else begin
            if (w_accept) begin
                r_par_sh <= '0;
            end else if (w_emit) begin
                r_par_sh <= {w_sum[0], r_par_sh[PW-1:1]};
            end
            if (w_finish) begin
                r_p_par <= r_par_sh;
            end
        end
    end

    assign p_par = r_p_par;
`endif

    assign busy        = r_busy;
    assign p_bit       = r_p_bit;
    assign p_vld       = r_p_vld;
    assign done        = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spm_seq_mult.sv
// tb_spm_seq_mult -- self-checking bench for spm_seq_mult with WIDTH=8.
//
// Each scenario task drives its own stimulus and checks its results inline.
// Expected products come from a plain-arithmetic model (ref_prod): both
// operands are extended to 2*W bits, multiplied, and the result truncated.
// Define SPM_PAR_OUT_EN to also exercise the p_par port.

module tb_spm_seq_mult;

    localparam int W  = 8;
    localparam int PW = 2 * W;

    logic          clk;
    logic          rst;
    logic          start;
    logic          sgn;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic          abort;
    logic          busy;
    logic          p_bit;
    logic          p_vld;
    logic          done;
    logic [1:0]    dbg_state;
`ifdef SPM_PAR_OUT_EN
    logic [PW-1:0] p_par;
`endif

    int checks = 0;
    int errors = 0;

    // Results recorded by run_op for the calling scenario to check.
    logic [PW-1:0] op_got;
    int            op_nvld;
    int            op_first;
    int            op_last;
    int            op_done_cyc;
    int            op_done_cnt;
    logic          op_busy0;
    logic          op_done_after;
    logic          op_busy_after;
`ifdef SPM_PAR_OUT_EN
    logic [PW-1:0] op_par;
`endif

    spm_seq_mult #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sgn         (sgn),
        .x           (x),
        .y           (y),
        .abort       (abort),
        .busy        (busy),
        .p_bit       (p_bit),
        .p_vld       (p_vld),
        .done        (done),
`ifdef SPM_PAR_OUT_EN
        .p_par       (p_par),
`endif
        .o_dbg_state (dbg_state)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog: the bench must always terminate on its own.
    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: extend both operands, multiply, truncate to 2*W bits.
    function automatic logic [PW-1:0] ref_prod(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [PW-1:0] ea;
        logic [PW-1:0] eb;
        ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    // Driver: issue one start at a negedge, then collect the stream up to done.
    // Cycle 0 is the negedge right after the accepting edge.
    // When pulse is set, start is toggled with x=7 throughout the operation.
    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input bit pulse);
        int cyc;
        op_got      = '0;
        op_nvld     = 0;
        op_first    = -1;
        op_last     = -1;
        op_done_cyc = -1;
        op_done_cnt = 0;
        sgn   = s;
        x     = a;
        y     = b;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        op_busy0 = busy;
        cyc      = 0;
        while (op_done_cnt == 0 && cyc < 60) begin
            if (p_vld) begin
                if (op_nvld < PW) op_got[op_nvld] = p_bit;
                if (op_first < 0) op_first = cyc;
                op_last = cyc;
                op_nvld++;
            end
            if (done) begin
                op_done_cnt++;
                op_done_cyc = cyc;
`ifdef SPM_PAR_OUT_EN
                op_par = p_par;
`endif
            end else begin
                if (pulse) begin
                    start = (cyc % 2 == 0);
                    x     = 8'h07;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        @(negedge clk);
        op_done_after = done;
        op_busy_after = busy;
    endtask

    task automatic test_reset;
        rst   = 1'b0;
        start = 1'b0;
        sgn   = 1'b0;
        x     = '0;
        y     = '0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy  !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (p_vld !== 1'b0) begin errors++; $display("FAIL reset_p_vld got=%b exp=0", p_vld); end
        checks++; if (p_bit !== 1'b0) begin errors++; $display("FAIL reset_p_bit got=%b exp=0", p_bit); end
        checks++; if (done  !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
`ifdef SPM_PAR_OUT_EN
        checks++; if (p_par !== '0) begin errors++; $display("FAIL reset_p_par got=%h exp=0", p_par); end
`endif
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_unsigned_max;
        run_op(1'b0, 8'hFF, 8'hFF, 1'b0);
        checks++; if (op_busy0 !== 1'b1) begin errors++; $display("FAIL umax_busy_after_accept got=%b exp=1", op_busy0); end
        checks++; if (op_got !== 16'hFE01) begin errors++; $display("FAIL umax_stream got=%h exp=fe01", op_got); end
        checks++; if (op_nvld !== PW) begin errors++; $display("FAIL umax_nvld got=%0d exp=%0d", op_nvld, PW); end
        checks++; if (op_first !== 1) begin errors++; $display("FAIL umax_first_vld got=%0d exp=1", op_first); end
        checks++; if (op_last !== PW) begin errors++; $display("FAIL umax_last_vld got=%0d exp=%0d", op_last, PW); end
        checks++; if (op_done_cyc !== PW + 1) begin errors++; $display("FAIL umax_done_cycle got=%0d exp=%0d", op_done_cyc, PW + 1); end
        checks++; if (op_done_after !== 1'b0) begin errors++; $display("FAIL umax_done_one_cycle got=%b exp=0", op_done_after); end
        checks++; if (op_busy_after !== 1'b0) begin errors++; $display("FAIL umax_busy_release got=%b exp=0", op_busy_after); end
    endtask

    task automatic test_signed;
        run_op(1'b1, 8'h80, 8'h80, 1'b0);
        checks++; if (op_got !== 16'h4000) begin errors++; $display("FAIL signed_min_sq got=%h exp=4000", op_got); end
        run_op(1'b1, 8'hFF, 8'h01, 1'b0);
        checks++; if (op_got !== 16'hFFFF) begin errors++; $display("FAIL signed_neg1 got=%h exp=ffff", op_got); end
        run_op(1'b1, 8'h7F, 8'h80, 1'b0);
        checks++; if (op_got !== ref_prod(1'b1, 8'h7F, 8'h80)) begin
            errors++; $display("FAIL signed_max_min got=%h exp=%h", op_got, ref_prod(1'b1, 8'h7F, 8'h80));
        end
    endtask

    task automatic test_ignore_start;
        run_op(1'b0, 8'h03, 8'h05, 1'b1);
        checks++; if (op_got !== 16'h000F) begin errors++; $display("FAIL busy_start_result got=%h exp=000f", op_got); end
        checks++; if (op_done_cnt !== 1) begin errors++; $display("FAIL busy_start_done got=%0d exp=1", op_done_cnt); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_no_second_op got=%b exp=0", busy); end
    endtask

    task automatic test_abort;
        int nv;
        int cyc;
        int late_done;
        int late_vld;
        sgn   = 1'b0;
        x     = 8'($urandom_range(0, 255));
        y     = 8'($urandom_range(0, 255));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nv    = 0;
        cyc   = 0;
        while (nv < 5 && cyc < 40) begin
            if (p_vld) nv++;
            if (nv < 5) begin
                @(negedge clk);
                cyc++;
            end
        end
        checks++; if (nv !== 5) begin errors++; $display("FAIL abort_reach_bit5 got=%0d exp=5", nv); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (p_vld !== 1'b0) begin errors++; $display("FAIL abort_p_vld got=%b exp=0", p_vld); end
        checks++; if (busy  !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        late_done = 0;
        late_vld  = 0;
        repeat (30) begin
            if (done)  late_done++;
            if (p_vld) late_vld++;
            @(negedge clk);
        end
        checks++; if (late_done !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", late_done); end
        checks++; if (late_vld  !== 0) begin errors++; $display("FAIL abort_no_vld got=%0d exp=0", late_vld); end
`ifdef SPM_PAR_OUT_EN
        checks++; if (p_par !== 16'h000F) begin errors++; $display("FAIL abort_p_par_kept got=%h exp=000f", p_par); end
`endif
        run_op(1'b0, 8'h02, 8'h02, 1'b0);
        checks++; if (op_got !== 16'h0004) begin errors++; $display("FAIL abort_next_op got=%h exp=0004", op_got); end
    endtask

    task automatic test_abort_vs_start;
        abort = 1'b1;
        start = 1'b1;
        x     = 8'h11;
        y     = 8'h22;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_beats_start busy got=%b exp=0", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_beats_start later busy got=%b exp=0", busy); end
    endtask

    task automatic test_async_reset;
        int nv;
        int cyc;
        sgn   = 1'b0;
        x     = 8'hA5;
        y     = 8'h5A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nv    = 0;
        cyc   = 0;
        while (nv < 3 && cyc < 40) begin
            if (p_vld) nv++;
            if (nv < 3) begin
                @(negedge clk);
                cyc++;
            end
        end
        checks++; if (nv !== 3) begin errors++; $display("FAIL rst_reach_bit3 got=%0d exp=3", nv); end
        rst = 1'b0;
        #1;
        checks++; if (busy  !== 1'b0) begin errors++; $display("FAIL async_rst_busy got=%b exp=0", busy); end
        checks++; if (p_vld !== 1'b0) begin errors++; $display("FAIL async_rst_p_vld got=%b exp=0", p_vld); end
        checks++; if (p_bit !== 1'b0) begin errors++; $display("FAIL async_rst_p_bit got=%b exp=0", p_bit); end
        checks++; if (done  !== 1'b0) begin errors++; $display("FAIL async_rst_done got=%b exp=0", done); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op(1'b0, 8'h12, 8'h34, 1'b0);
        checks++; if (op_got !== 16'h03A8) begin errors++; $display("FAIL rst_next_op got=%h exp=03a8", op_got); end
    endtask

    task automatic test_random;
        logic          s;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [PW-1:0] exp;
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            if (i == 0) begin a = 8'h00; b = 8'hFF; end
            if (i == 1) begin a = 8'h80; b = 8'h7F; s = 1'b0; end
            exp = ref_prod(s, a, b);
            run_op(s, a, b, 1'b0);
            checks++; if (op_got !== exp) begin
                errors++; $display("FAIL random_%0d sgn=%b x=%h y=%h got=%h exp=%h", i, s, a, b, op_got, exp);
            end
            checks++; if (op_nvld !== PW || op_done_cyc !== PW + 1) begin
                errors++; $display("FAIL random_timing_%0d nvld=%0d done_cyc=%0d exp=%0d/%0d", i, op_nvld, op_done_cyc, PW, PW + 1);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [PW-1:0] exp_q[$];
        logic [PW-1:0] exp;
        logic          s;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        for (int i = 0; i < 6; i++) begin
            s = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(ref_prod(s, a, b));
            run_op(s, a, b, 1'b0);
            exp = exp_q.pop_front();
            checks++; if (op_got !== exp || op_busy0 !== 1'b1) begin
                errors++; $display("FAIL back_to_back_%0d got=%h busy=%b exp=%h busy=1", i, op_got, op_busy0, exp);
            end
        end
    endtask

`ifdef SPM_PAR_OUT_EN
    task automatic test_par_out;
        run_op(1'b0, 8'hFF, 8'hFF, 1'b0);
        checks++; if (op_par !== 16'hFE01) begin errors++; $display("FAIL par_done_cycle got=%h exp=fe01", op_par); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (p_par !== 16'hFE01) begin errors++; $display("FAIL par_hold_%0d got=%h exp=fe01", i, p_par); end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed();
        test_ignore_start();
        test_abort();
        test_abort_vs_start();
        test_async_reset();
        test_random();
        test_back_to_back();
`ifdef SPM_PAR_OUT_EN
        test_par_out();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
